// File: rtl/ysyx_22040895_fetch_buf.sv
// rtl/ysyx_22040895_fetch_buf.sv - instruction-fetch front end with prefetch FIFO and redirect flush
//
// Issues in-order fetch requests, buffers up to DEPTH returned instructions
// with their PCs, and presents the oldest one to the decoder.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid_o/req_ready_i  fetch request handshake, address on req_addr_o
//   resp_valid_i/resp_data_i one in-order response per accepted request
//   inst_valid_o/inst_ready_i decoder handshake, head entry on inst_o/pc_o
//   redirect_i/redirect_pc_i flush and restart fetch at a new PC
module ysyx_22040895_fetch_buf #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              resp_valid_i,
    input  logic [INST_W-1:0] resp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q,     drop_d;
    logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];

    logic [CW:0] used;
    logic        req_fire;
    logic        resp_ok;
    logic        push;
    logic        pop;

    // Buffered entries plus outstanding requests never exceed DEPTH, so a
    // response always has a free slot to land in.
    assign used        = {1'b0, count_q} + {1'b0, inflight_q};
    assign req_valid_o = !rst && !redirect_i && (used < (CW+1)'(DEPTH));
    assign req_addr_o  = fetch_pc_q;

    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_mem_q[rd_ptr_q];
    assign pc_o         = pc_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;

        // A response with nothing outstanding is a bus protocol error; ignore it.
        resp_ok  = resp_valid_i && (inflight_q != '0);
        req_fire = req_valid_o && req_ready_i;
        push     = resp_ok && (drop_q == '0) && !redirect_i;
        pop      = inst_valid_o && inst_ready_i && !redirect_i;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~ADDR_W'(3);
            resp_pc_d  = redirect_pc_i & ~ADDR_W'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Every request still outstanding after this cycle belongs to the
            // old path, including any we were already dropping.
            inflight_d = inflight_q - CW'(resp_ok);
            drop_d     = inflight_q - CW'(resp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
            if (resp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]   = resp_pc_q;
                inst_mem_d[wr_ptr_q] = resp_data_i;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                resp_pc_d            = resp_pc_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule
